// File: rtl/parity_rr_fifo_if.sv
// parity_rr_fifo_if: push channels, arbitrated output port and occupancy of the parity round-robin FIFO
interface parity_rr_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int NUM_CH     = 2
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    logic [NUM_CH-1:0]            push_valid_i;
    logic [NUM_CH*DATA_WIDTH-1:0] push_data_i;
    logic [NUM_CH-1:0]            push_grant_o;
    logic                         valid_o;
    logic [DATA_WIDTH:0]          data_o;
    logic [CW-1:0]                ch_o;
    logic                         grant_i;
    logic [NUM_CH*LW-1:0]         level_o;
    modport master (
        output push_valid_i, push_data_i, grant_i,
        input  push_grant_o, valid_o, data_o, ch_o, level_o
    );
    modport slave (
        input  push_valid_i, push_data_i, grant_i,
        output push_grant_o, valid_o, data_o, ch_o, level_o
    );
endinterface

// File: rtl/parity_rr_fifo.sv
// parity_rr_fifo: per-channel parity FIFOs drained round-robin onto one valid/grant port
package types_pkg;
    typedef enum logic {EVEN, ODD} parity_mode_e;
    typedef enum logic {MSB, LSB} parity_pos_e;
endpackage

module parity_rr_fifo
    import types_pkg::*;
#(
    parameter int           DATA_WIDTH        = 8,
    parameter int           DEPTH             = 4,
    parameter int           NUM_CH            = 2,
    parameter parity_mode_e PARITY_MODE       = EVEN,
    parameter parity_pos_e  PARITY_BIT_CHOICE = MSB
) (
    input logic            clk,
    input logic            reset_n,
    parity_rr_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int W  = DATA_WIDTH + 1;

    logic [W-1:0]      head [NUM_CH];
    logic [NUM_CH-1:0] ne;
    logic [CW-1:0]     rr, pick, k, sel, held_ch;
    logic              held, pop;

    // Words are stored already encoded, so the read side is a plain mux.
    function automatic logic [W-1:0] encode(input logic [DATA_WIDTH-1:0] d);
        logic p;
        p = (^d) ^ (PARITY_MODE == ODD);
        return PARITY_BIT_CHOICE == MSB ? {p, d} : {d, p};
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [W-1:0]  mem [DEPTH];
        logic [LW-1:0] wr, rd, lvl;
        logic          push, pop_c;
        assign lvl                       = wr - rd;
        assign ne[c]                     = wr != rd;
        assign head[c]                   = mem[rd[AW-1:0]];
        assign bus.push_grant_o[c]       = lvl != LW'(DEPTH);
        assign bus.level_o[c*LW +: LW]   = lvl;
        assign push                      = bus.push_valid_i[c] & bus.push_grant_o[c];
        assign pop_c                     = pop & (sel == CW'(c));
        // Pointer pair with wrap bit; push and pop may both advance in one cycle.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wr <= '0;
                rd <= '0;
            end else begin
                wr <= wr + LW'(push);
                rd <= rd + LW'(pop_c);
            end
        end
        // Storage is never reset; stale contents are unreachable once pointers clear.
        always_ff @(posedge clk) begin
            if (push) mem[wr[AW-1:0]] <= encode(bus.push_data_i[c*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Scan from highest offset down so the first non-empty channel at or after rr wins.
    always_comb begin
        pick = '0;
        k    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            k    = CW'((int'(rr) + i) % NUM_CH);
            pick = ne[k] ? k : pick;
        end
    end

    assign sel         = held ? held_ch : pick;
    assign pop         = bus.valid_o & bus.grant_i;
    assign bus.valid_o = ne[sel];
    assign bus.data_o  = bus.valid_o ? head[sel] : '0;
    assign bus.ch_o    = sel;

    // Freeze the selection while a word is offered but not taken; advance rr past each popped channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr      <= '0;
            held    <= 1'b0;
            held_ch <= '0;
        end else begin
            held    <= bus.valid_o & ~bus.grant_i;
            held_ch <= sel;
            if (pop) rr <= (sel == CW'(NUM_CH - 1)) ? '0 : sel + CW'(1);
        end
    end
endmodule

// File: tb/tb_parity_rr_fifo.sv
// tb_parity_rr_fifo: queue-model checks of the parity round-robin FIFO (2 channels) plus 1-channel parity variants
module tb_parity_rr_fifo;
    import types_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    parity_rr_fifo_if #(.DATA_WIDTH(8), .DEPTH(4), .NUM_CH(2)) m ();
    parity_rr_fifo_if #(.DATA_WIDTH(8), .DEPTH(4), .NUM_CH(1)) s1 ();
    parity_rr_fifo_if #(.DATA_WIDTH(8), .DEPTH(4), .NUM_CH(1)) s2 ();

    parity_rr_fifo #(.DATA_WIDTH(8), .DEPTH(4), .NUM_CH(2), .PARITY_MODE(EVEN), .PARITY_BIT_CHOICE(MSB))
        dut (.clk(clk), .reset_n(reset_n), .bus(m));
    parity_rr_fifo #(.DATA_WIDTH(8), .DEPTH(4), .NUM_CH(1), .PARITY_MODE(EVEN), .PARITY_BIT_CHOICE(MSB))
        dut_em (.clk(clk), .reset_n(reset_n), .bus(s1));
    parity_rr_fifo #(.DATA_WIDTH(8), .DEPTH(4), .NUM_CH(1), .PARITY_MODE(ODD), .PARITY_BIT_CHOICE(LSB))
        dut_ol (.clk(clk), .reset_n(reset_n), .bus(s2));

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: one queue per channel, round-robin start and held channel.
    logic [7:0] q [2][$];
    int rr_m, hold_m, e_sel;
    logic e_valid, e_ch;
    logic [8:0] e_data;
    logic [1:0] e_grant;
    logic [5:0] e_lvl;

    function automatic logic [8:0] enc(input logic [7:0] d);
        return {1'($countones(d) % 2), d};
    endfunction

    task automatic compute();
        e_sel = -1;
        if (hold_m >= 0) e_sel = hold_m;
        else
            for (int i = 0; i < 2; i++)
                if (e_sel < 0 && q[(rr_m + i) % 2].size() > 0) e_sel = (rr_m + i) % 2;
        e_valid = e_sel >= 0;
        e_data  = e_valid ? enc(q[e_sel][0]) : 9'h0;
        e_ch    = e_valid ? 1'(e_sel) : 1'b0;
        for (int c = 0; c < 2; c++) begin
            e_grant[c]       = q[c].size() != 4;
            e_lvl[c*3 +: 3]  = 3'(q[c].size());
        end
    endtask

    task automatic advance(input logic [1:0] pv, input logic [7:0] d0, input logic [7:0] d1, input logic g);
        logic a0, a1;
        int popc;
        m.push_valid_i = pv;
        m.push_data_i  = {d1, d0};
        m.grant_i      = g;
        compute();
        a0   = pv[0] && q[0].size() < 4;
        a1   = pv[1] && q[1].size() < 4;
        popc = (e_valid && g) ? e_sel : -1;
        @(posedge clk);
        if (popc >= 0) begin
            void'(q[popc].pop_front());
            rr_m   = (popc + 1) % 2;
            hold_m = -1;
        end else hold_m = e_valid ? e_sel : -1;
        if (a0) q[0].push_back(d0);
        if (a1) q[1].push_back(d1);
        @(negedge clk);
        compute();
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        m.push_valid_i = '0; m.push_data_i = '0; m.grant_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        q[0].delete(); q[1].delete();
        rr_m = 0; hold_m = -1;
        compute();
    endtask

    task automatic test_reset();
        reset_dut();
        n_cmp++; if (m.push_grant_o !== 2'b11) begin n_fail++; $display("FAIL reset_grant: got %b want 11", m.push_grant_o); end
        n_cmp++; if (m.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m.valid_o); end
        n_cmp++; if (m.level_o !== 6'd0) begin n_fail++; $display("FAIL reset_level: got %h want 0", m.level_o); end
        n_cmp++; if (m.data_o !== 9'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", m.data_o); end
        n_cmp++; if (m.ch_o !== 1'b0) begin n_fail++; $display("FAIL reset_ch: got %b want 0", m.ch_o); end
        n_cmp++; if (s1.valid_o !== 1'b0 || s1.push_grant_o !== 1'b1) begin n_fail++; $display("FAIL reset_single: valid %b grant %b want 0/1", s1.valid_o, s1.push_grant_o); end
    endtask

    task automatic test_parity();
        s1.push_valid_i = 1'b1; s1.push_data_i = 8'b0000_0111; s1.grant_i = 1'b0;
        s2.push_valid_i = 1'b1; s2.push_data_i = 8'b0000_0111; s2.grant_i = 1'b0;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (s1.valid_o !== 1'b1 || s1.data_o !== 9'b1_0000_0111) begin n_fail++; $display("FAIL parity_even_msb_07: got %b/%b want 1/100000111", s1.valid_o, s1.data_o); end
        n_cmp++; if (s2.data_o !== 9'b0000_0111_0) begin n_fail++; $display("FAIL parity_odd_lsb_07: got %b want 000001110", s2.data_o); end
        n_cmp++; if (s1.ch_o !== 1'b0) begin n_fail++; $display("FAIL single_ch: got %b want 0", s1.ch_o); end
        s1.push_data_i = 8'b1011_0001; s1.grant_i = 1'b1;
        s2.push_data_i = 8'b1011_0001; s2.grant_i = 1'b1;
        @(posedge clk); @(negedge clk);
        s1.push_valid_i = 1'b0; s2.push_valid_i = 1'b0;
        n_cmp++; if (s1.data_o !== 9'b0_1011_0001) begin n_fail++; $display("FAIL parity_even_msb_b1: got %b want 010110001", s1.data_o); end
        n_cmp++; if (s2.data_o !== 9'b1011_0001_1) begin n_fail++; $display("FAIL parity_odd_lsb_b1: got %b want 101100011", s2.data_o); end
        @(posedge clk); @(negedge clk);
        s1.grant_i = 1'b0; s2.grant_i = 1'b0;
        n_cmp++; if (s1.valid_o !== 1'b0 || s2.valid_o !== 1'b0) begin n_fail++; $display("FAIL parity_drain: valid %b %b want 0 0", s1.valid_o, s2.valid_o); end
    endtask

    task automatic test_full_wrap();
        logic [7:0] d [8];
        reset_dut();
        for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) advance(2'b01, d[i], 8'h0, 1'b0);
        n_cmp++; if (m.push_grant_o[0] !== 1'b0) begin n_fail++; $display("FAIL full_grant: got %b want 0", m.push_grant_o[0]); end
        n_cmp++; if (m.level_o[2:0] !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d want 4", m.level_o[2:0]); end
        n_cmp++; if (m.data_o !== enc(d[0])) begin n_fail++; $display("FAIL full_head: got %h want %h", m.data_o, enc(d[0])); end
        advance(2'b01, 8'hEE, 8'h0, 1'b1);
        n_cmp++; if (m.level_o[2:0] !== 3'd3) begin n_fail++; $display("FAIL full_push_rejected: level %0d want 3", m.level_o[2:0]); end
        for (int i = 1; i < 4; i++) begin
            n_cmp++; if (m.data_o !== enc(d[i])) begin n_fail++; $display("FAIL drain_order[%0d]: got %h want %h", i, m.data_o, enc(d[i])); end
            advance(2'b00, 8'h0, 8'h0, 1'b1);
        end
        n_cmp++; if (m.valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_empty: valid %b want 0", m.valid_o); end
        for (int i = 4; i < 8; i++) advance(2'b01, d[i], 8'h0, 1'b0);
        n_cmp++; if (m.push_grant_o[0] !== 1'b0 || m.level_o[2:0] !== 3'd4) begin n_fail++; $display("FAIL wrap_full: grant %b level %0d want 0/4", m.push_grant_o[0], m.level_o[2:0]); end
        for (int i = 4; i < 8; i++) begin
            n_cmp++; if (m.data_o !== enc(d[i])) begin n_fail++; $display("FAIL wrap_order[%0d]: got %h want %h", i, m.data_o, enc(d[i])); end
            advance(2'b00, 8'h0, 8'h0, 1'b1);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] w [4];
        logic exp_ch [4];
        reset_dut();
        for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
        exp_ch = '{1'b0, 1'b1, 1'b0, 1'b1};
        advance(2'b11, w[0], w[1], 1'b0);
        advance(2'b11, w[2], w[3], 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (m.valid_o !== 1'b1 || m.data_o !== enc(w[i]) || m.ch_o !== exp_ch[i]) begin n_fail++; $display("FAIL rr_seq[%0d]: got v%b %h ch%b want v1 %h ch%b", i, m.valid_o, m.data_o, m.ch_o, enc(w[i]), exp_ch[i]); end
            advance(2'b00, 8'h0, 8'h0, 1'b1);
        end
        n_cmp++; if (m.valid_o !== 1'b0) begin n_fail++; $display("FAIL rr_empty: valid %b want 0", m.valid_o); end
    endtask

    task automatic test_hold();
        logic [7:0] a, b;
        reset_dut();
        a = 8'($urandom); b = 8'($urandom);
        advance(2'b01, 8'($urandom), 8'h0, 1'b0);
        advance(2'b00, 8'h0, 8'h0, 1'b1);
        advance(2'b01, a, 8'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            advance(i == 0 ? 2'b10 : 2'b00, 8'h0, b, 1'b0);
            n_cmp++; if (m.data_o !== enc(a) || m.ch_o !== 1'b0) begin n_fail++; $display("FAIL hold[%0d]: got %h ch%b want %h ch0", i, m.data_o, m.ch_o, enc(a)); end
        end
        advance(2'b00, 8'h0, 8'h0, 1'b1);
        n_cmp++; if (m.data_o !== enc(b) || m.ch_o !== 1'b1) begin n_fail++; $display("FAIL hold_release: got %h ch%b want %h ch1", m.data_o, m.ch_o, enc(b)); end
        advance(2'b00, 8'h0, 8'h0, 1'b1);
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            logic g;
            g = ((i / 40) % 2 == 1) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            advance(2'($urandom), 8'($urandom), 8'($urandom), g);
            n_cmp++; if (m.valid_o !== e_valid) begin n_fail++; $display("FAIL rand_valid@%0d: got %b want %b", i, m.valid_o, e_valid); end
            n_cmp++; if (m.data_o !== e_data) begin n_fail++; $display("FAIL rand_data@%0d: got %h want %h", i, m.data_o, e_data); end
            n_cmp++; if (m.ch_o !== e_ch) begin n_fail++; $display("FAIL rand_ch@%0d: got %b want %b", i, m.ch_o, e_ch); end
            n_cmp++; if (m.push_grant_o !== e_grant) begin n_fail++; $display("FAIL rand_grant@%0d: got %b want %b", i, m.push_grant_o, e_grant); end
            n_cmp++; if (m.level_o !== e_lvl) begin n_fail++; $display("FAIL rand_level@%0d: got %h want %h", i, m.level_o, e_lvl); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        reset_dut();
        for (int i = 0; i < 3; i++) advance(2'b01, 8'($urandom), 8'h0, 1'b0);
        n_cmp++; if (m.valid_o !== 1'b1 || m.level_o[2:0] !== 3'd3) begin n_fail++; $display("FAIL mid_pre: valid %b level %0d want 1/3", m.valid_o, m.level_o[2:0]); end
        #2;
        reset_n = 1'b0;
        m.push_valid_i = '0; m.grant_i = 1'b0;
        #1;
        n_cmp++; if (m.valid_o !== 1'b0 || m.level_o !== 6'd0 || m.data_o !== 9'd0 || m.push_grant_o !== 2'b11) begin n_fail++; $display("FAIL mid_reset: valid %b level %h data %h grant %b want 0/0/0/11", m.valid_o, m.level_o, m.data_o, m.push_grant_o); end
        #1;
        reset_n = 1'b1;
        q[0].delete(); q[1].delete();
        rr_m = 0; hold_m = -1;
        @(negedge clk);
        compute();
        w = 8'($urandom);
        advance(2'b01, w, 8'h0, 1'b0);
        n_cmp++; if (m.valid_o !== 1'b1 || m.data_o !== enc(w) || m.ch_o !== 1'b0 || m.level_o !== 6'd1) begin n_fail++; $display("FAIL mid_after: v%b %h ch%b lvl %h want v1 %h ch0 lvl 01", m.valid_o, m.data_o, m.ch_o, m.level_o, enc(w)); end
    endtask

    initial begin
        s1.push_valid_i = 1'b0; s1.push_data_i = '0; s1.grant_i = 1'b0;
        s2.push_valid_i = 1'b0; s2.push_data_i = '0; s2.grant_i = 1'b0;
        test_reset();
        test_parity();
        test_full_wrap();
        test_round_robin();
        test_hold();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
